load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and DataMemory. Accepts one RV32I load or store per request.
//  Produces DataMemory's word address, write_data, write_mask and write_enable.
//  Splits any access that crosses a 32-bit word boundary into two sequential word accesses.
//  Formats load data with sign or zero extension and returns it with a one-cycle response pulse.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width of DataMemory (2^ADDR_WIDTH words; byte space 4*2^ADDR_WIDTH)
// PORTS
//  clk                 in   1   clock; all state updates on posedge
//  reset_n             in   1   asynchronous, active-low reset
//  req_valid           in   1   request present
//  req_ready           out  1   unit can accept; high only in IDLE
//  req_is_store        in   1   1 = store, 0 = load
//  req_funct3          in   3   RV32I funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//  req_addr            in   32  byte address
//  req_store_data      in   32  store data, right-aligned
//  dmem_address        out  ADDR_WIDTH  word address to DataMemory
//  dmem_write_enable   out  1   DataMemory write enable
//  dmem_write_data     out  32  lane-aligned write data
//  dmem_write_mask     out  4   byte-lane mask; bit i = byte i
//  dmem_read_data      in   32  DataMemory combinational read data
//  resp_valid          out  1   one-cycle pulse: access complete
//  resp_fault          out  1   valid with resp_valid: access rejected
//  resp_load_data      out  32  extended load result; 0 for stores and faults
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; all request registers and buffers cleared.
//   - Outputs: req_ready=1; resp_*=0; dmem_* = 0.
//   - Any in-flight access is dropped; no dmem write after reset asserts, since write_enable decodes from state.
//  Accept:
//   - Request is registered on posedge with req_valid & req_ready.
//   - Nothing downstream depends on req_* after acceptance.
//  Decode:
//   - size n = 1/2/4 from funct3[1:0]; off = addr[1:0]; W = addr[ADDR_WIDTH+1:2].
//   - split = (off + n > 4).
//  Fault (decided at accept, no memory write ever issued):
//   - Illegal funct3: load 3/6/7, store >= 3.
//   - addr[31:ADDR_WIDTH+2] != 0.
//   - split with W = all-ones. There is no wrap-around to word 0.
//  Lane formatting: 64-bit lane = {32'b0, store_data} << 8*off; 8-bit mask = ((1<<n)-1) << off.
//   - Word W uses lane[31:0] and mask[3:0].
//   - Word W+1 uses lane[63:32] and mask[7:4].
//  States:
//   - IDLE: req_ready=1. On accept: fault -> RESP, else -> ACC0.
//   - ACC0: dmem_address=W; write_enable=is_store; data/mask = low half. Capture read data into buf0.
//     split -> ACC1, else -> RESP.
//   - ACC1: dmem_address=W+1; write_enable=is_store; data/mask = high half. Capture read data into buf1.
//     -> RESP.
//   - RESP: resp_valid=1, resp_fault and resp_load_data registered. -> IDLE. No backpressure.
//   - dmem_* are 0 in IDLE and RESP.
//  Load result: {buf1,buf0} >> 8*off, low n bytes.
//   - Sign-extend if funct3[2]=0, else zero-extend.
//   - LW returns the word unchanged.
//  Latency, accept edge to resp_valid high:
//   - Non-split: 2 cycles.
//   - Split: 3 cycles.
//   - Fault: 1 cycle.
//   - Next accept is possible the cycle after RESP.
//  Split store: not atomic. A reset between ACC0 and ACC1 leaves word W written and word W+1 untouched.
// TESTING
//  SW addr 0x010 data 0xDEADBEEF -> ACC0: addr 4, mask 1111, data 0xDEADBEEF; resp 2 cycles later, fault 0.
//  Then LW 0x010 -> resp_load_data 0xDEADBEEF. LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE.
//  SB 0x013 data 0x000000AB -> single access: addr 4, mask 1000, data 0xAB000000.
//  SH 0x00F data 0xBEEF:
//   - ACC0: addr 3, mask 1000, data 0xEF000000.
//   - ACC1: addr 4, mask 0001, data 0x000000BE.
//   - Then LH 0x00F -> 0xFFFFBEEF; LHU -> 0x0000BEEF; resp 3 cycles after accept.
//  Faults, each resp_fault=1, load data 0, write_enable never 1:
//   - LW 0x1000 (out of range).
//   - LW 0xFFE (split at W=1023).
//   - Load funct3=3.
//  Split SW 0x00E: assert reset_n=0 during ACC1.
//   - dmem_write_enable drops immediately; word 3 updated, word 4 unchanged.
//   - resp_valid never pulses; req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, DataMemory and response signals between execute stage, LSU and DataMemory.
// Latency: none (wires only).
// Backpressure: req_ready from the LSU; the response channel has no backpressure.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 10);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_store_data;
    logic [ADDR_WIDTH-1:0] dmem_address;
    logic                  dmem_write_enable;
    logic [31:0]           dmem_write_data;
    logic [3:0]            dmem_write_mask;
    logic [31:0]           dmem_read_data;
    logic                  resp_valid;
    logic                  resp_fault;
    logic [31:0]           resp_load_data;

    // LSU side
    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_store_data, dmem_read_data,
        output req_ready, dmem_address, dmem_write_enable, dmem_write_data, dmem_write_mask,
               resp_valid, resp_fault, resp_load_data
    );

    // Execute stage / DataMemory side
    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_store_data, dmem_read_data,
        input  req_ready, dmem_address, dmem_write_enable, dmem_write_data, dmem_write_mask,
               resp_valid, resp_fault, resp_load_data
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: splits word-crossing accesses, lane-aligns stores, extends loads.
// Latency: accept to resp_valid = 1 (fault), 2 (single word), 3 (split) cycles.
// Backpressure: req_ready only in IDLE; response is a one-cycle pulse with no stall.
module load_store_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state_q, state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic                  split_q;
    logic                  fault_q;
    logic [63:0]           lane_q;
    logic [7:0]            mask_q;
    logic [31:0]           buf0_q;
    logic [31:0]           buf1_q;

    logic                  accept;
    logic [3:0]            size_mask;
    logic [3:0]            size_n;
    logic                  split_dec;
    logic                  illegal_dec;
    logic                  fault_dec;
    logic [63:0]           lane_dec;
    logic [7:0]            mask_dec;
    logic [31:0]           shifted;
    logic [31:0]           load_fmt;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Decode the incoming request: size, split, fault and lane-aligned data/mask for both words
    always_comb begin
        case (bus.req_funct3[1:0])
            2'd0:    begin size_n = 4'd1; size_mask = 4'b0001; end
            2'd1:    begin size_n = 4'd2; size_mask = 4'b0011; end
            default: begin size_n = 4'd4; size_mask = 4'b1111; end
        endcase
        split_dec = ({2'b00, bus.req_addr[1:0]} + size_n) > 4'd4;
        if (bus.req_is_store)
            illegal_dec = bus.req_funct3 >= 3'd3;
        else
            illegal_dec = !(bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        // Split at the top word would need word 0 next; that wrap is rejected, not performed
        fault_dec = illegal_dec
                  || (|bus.req_addr[31:ADDR_WIDTH+2])
                  || (split_dec && (&bus.req_addr[ADDR_WIDTH+1:2]));
        lane_dec = {32'b0, bus.req_store_data} << {bus.req_addr[1:0], 3'b000};
        mask_dec = {4'b0000, size_mask} << bus.req_addr[1:0];
    end

    // Align the two captured words back down to the access offset and extend
    always_comb begin
        shifted = 32'({buf1_q, buf0_q} >> {off_q, 3'b000});
        case (funct3_q[1:0])
            2'd0:    load_fmt = {{24{~funct3_q[2] & shifted[7]}},  shifted[7:0]};
            2'd1:    load_fmt = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    // State register; reset drops any in-flight access, which also kills write_enable at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Request capture on accept and read-data capture in each access cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            word_q     <= '0;
            split_q    <= 1'b0;
            fault_q    <= 1'b0;
            lane_q     <= 64'd0;
            mask_q     <= 8'd0;
            buf0_q     <= 32'd0;
            buf1_q     <= 32'd0;
        end else begin
            if (accept) begin
                is_store_q <= bus.req_is_store;
                funct3_q   <= bus.req_funct3;
                off_q      <= bus.req_addr[1:0];
                word_q     <= bus.req_addr[ADDR_WIDTH+1:2];
                split_q    <= split_dec;
                fault_q    <= fault_dec;
                lane_q     <= lane_dec;
                mask_q     <= mask_dec;
                buf0_q     <= 32'd0;
                buf1_q     <= 32'd0;
            end
            if (state_q == ACC0) buf0_q <= bus.dmem_read_data;
            if (state_q == ACC1) buf1_q <= bus.dmem_read_data;
        end
    end

    // Next state and all outputs decoded from the registered state
    always_comb begin
        state_d               = state_q;
        bus.req_ready         = 1'b0;
        bus.dmem_address      = '0;
        bus.dmem_write_enable = 1'b0;
        bus.dmem_write_data   = 32'd0;
        bus.dmem_write_mask   = 4'd0;
        bus.resp_valid        = 1'b0;
        bus.resp_fault        = 1'b0;
        bus.resp_load_data    = 32'd0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_d = fault_dec ? RESP : ACC0;
            end
            ACC0: begin
                bus.dmem_address      = word_q;
                bus.dmem_write_enable = is_store_q;
                bus.dmem_write_data   = lane_q[31:0];
                bus.dmem_write_mask   = mask_q[3:0];
                state_d               = split_q ? ACC1 : RESP;
            end
            ACC1: begin
                bus.dmem_address      = word_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                bus.dmem_write_enable = is_store_q;
                bus.dmem_write_data   = lane_q[63:32];
                bus.dmem_write_mask   = mask_q[7:4];
                state_d               = RESP;
            end
            default: begin
                bus.resp_valid     = 1'b1;
                bus.resp_fault     = fault_q;
                bus.resp_load_data = (fault_q || is_store_q) ? 32'd0 : load_fmt;
                state_d            = IDLE;
            end
        endcase
    end
endmodule
